// File: rtl/e_stage_md_pkg.sv
// e_stage_pkg: opcode encodings and default latencies shared by the execute stage and its MDU.
package e_stage_pkg;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_LUI  = 4'd8;
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  function automatic logic is_md_start(input logic [3:0] op);
    return op >= MD_MULT && op <= MD_DIVU;
  endfunction
  function automatic logic is_mul(input logic [3:0] op);
    return op == MD_MULT || op == MD_MULTU;
  endfunction
endpackage

// File: rtl/e_stage_md_md_unit.sv
// md_unit: multi-cycle multiply/divide with HI/LO; result is committed when the busy counter expires.
module md_unit
  import e_stage_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             e_valid_i,
  input  logic [3:0]       md_op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  output logic             start_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  logic busy_q, busy_d, done;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] ax, bx, uq, ur;
  logic signed [WIDTH-1:0] sq, sr;
  logic [2*WIDTH-1:0] prod;
  assign start_o = e_valid_i & ~busy_q & is_md_start(md_op_i);
  assign done    = busy_q && cnt_q == CW'(1);
  assign busy_o  = busy_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both MULT and MULTU.
  assign ax   = op_q == MD_MULT ? {WIDTH{a_q[WIDTH-1]}} : '0;
  assign bx   = op_q == MD_MULT ? {WIDTH{b_q[WIDTH-1]}} : '0;
  assign prod = {ax, a_q} * {bx, b_q};
  assign sq   = $signed(a_q) / $signed(b_q);
  assign sr   = $signed(a_q) % $signed(b_q);
  assign uq   = a_q / b_q;
  assign ur   = a_q % b_q;
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (start_o) begin
      busy_d = 1'b1;
      cnt_d  = is_mul(md_op_i) ? MULT_LOAD : DIV_LOAD;
      op_d   = md_op_i;
      a_d    = rs_i;
      b_d    = rt_i;
    end else if (busy_q) begin
      cnt_d  = cnt_q - CW'(1);
      busy_d = ~done;
    end
    if (done) begin
      if (is_mul(op_q))
        {hi_d, lo_d} = prod;
      else if (b_q != '0) begin
        if (op_q == MD_DIVU)
          {hi_d, lo_d} = {ur, uq};
        else if (a_q == MIN && b_q == '1)
          {hi_d, lo_d} = {{WIDTH{1'b0}}, MIN};
        else
          {hi_d, lo_d} = {sr, sq};
      end
    end
    if (e_valid_i && !busy_q && md_op_i == MD_MTHI) hi_d = rs_i;
    if (e_valid_i && !busy_q && md_op_i == MD_MTLO) lo_d = rs_i;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= MD_NONE;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end
endmodule

// File: rtl/e_stage_md.sv
// e_stage_md: MIPS execute stage with combinational ALU, link and HI/LO result mux around a multi-cycle MDU.
module e_stage_md
  import e_stage_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             e_valid,
  input  logic [3:0]       alu_op,
  input  logic             b_sel,
  input  logic [3:0]       md_op,
  input  logic             is_link,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] fwd_rs,
  input  logic [WIDTH-1:0] fwd_rt,
  input  logic [WIDTH-1:0] ext_imm,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] rt_pass,
  output logic             md_start,
  output logic             md_busy
);
  logic [WIDTH-1:0] b, alu_y, hi, lo;
  logic slt, sltu;
  assign b       = b_sel ? ext_imm : fwd_rt;
  assign slt     = $signed(fwd_rs) < $signed(b);
  assign sltu    = fwd_rs < b;
  assign rt_pass = fwd_rt;
  always_comb begin
    alu_y = alu_op == ALU_ADD  ? fwd_rs + b :
            alu_op == ALU_SUB  ? fwd_rs - b :
            alu_op == ALU_AND  ? fwd_rs & b :
            alu_op == ALU_OR   ? fwd_rs | b :
            alu_op == ALU_XOR  ? fwd_rs ^ b :
            alu_op == ALU_NOR  ? ~(fwd_rs | b) :
            alu_op == ALU_SLT  ? {{(WIDTH-1){1'b0}}, slt} :
            alu_op == ALU_SLTU ? {{(WIDTH-1){1'b0}}, sltu} :
            alu_op == ALU_LUI  ? b << (WIDTH/2) : '0;
    result = is_link           ? pc + WIDTH'(8) :
             md_op == MD_MFHI  ? hi :
             md_op == MD_MFLO  ? lo : alu_y;
  end
  md_unit #(
    .WIDTH      (WIDTH),
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md (
    .clk      (clk),
    .reset    (reset),
    .e_valid_i(e_valid),
    .md_op_i  (md_op),
    .rs_i     (fwd_rs),
    .rt_i     (fwd_rt),
    .start_o  (md_start),
    .busy_o   (md_busy),
    .hi_o     (hi),
    .lo_o     (lo)
  );
endmodule

// File: tb/tb_e_stage_md.sv
// tb_e_stage_md: table-driven ALU vectors, directed MDU sequences and randomized MDU/ALU traffic against a reference model.
module tb_e_stage_md;
  import e_stage_pkg::*;
  logic clk = 1'b0, reset, e_valid, b_sel, is_link, md_start, md_busy;
  logic [3:0] alu_op, md_op;
  logic [31:0] pc, fwd_rs, fwd_rt, ext_imm, result, rt_pass;
  logic [15:0] pc16, rs16, rt16, imm16, result16, rt_pass16;
  logic [3:0] md_op16;
  logic link16, md_start16, md_busy16;
  int checks = 0, errors = 0;
  logic [31:0] hi_m = '0, lo_m = '0;
  typedef struct {
    logic [3:0]  op;
    logic        bsel;
    logic        link;
    logic [31:0] rs, rt, imm, pc, exp;
    string       name;
  } vec_t;
  vec_t tbl[14];
  always #5 clk = ~clk;
  e_stage_md dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .alu_op(alu_op), .b_sel(b_sel),
    .md_op(md_op), .is_link(is_link), .pc(pc), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .ext_imm(ext_imm), .result(result), .rt_pass(rt_pass), .md_start(md_start), .md_busy(md_busy)
  );
  e_stage_md #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .e_valid(e_valid), .alu_op(alu_op), .b_sel(b_sel),
    .md_op(md_op16), .is_link(link16), .pc(pc16), .fwd_rs(rs16), .fwd_rt(rt16),
    .ext_imm(imm16), .result(result16), .rt_pass(rt_pass16), .md_start(md_start16), .md_busy(md_busy16)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    e_valid = 1'b0; md_op = MD_NONE; is_link = 1'b0; b_sel = 1'b0; alu_op = ALU_ADD;
  endtask
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_LUI:  return b * 32'd65536;
      default:  return 32'd0;
    endcase
  endfunction
  task automatic model_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == MD_MULT) begin
      q = sa * sb; hi_m = q[63:32]; lo_m = q[31:0];
    end else if (op == MD_MULTU) begin
      p = {32'd0, a} * {32'd0, b}; hi_m = p[63:32]; lo_m = p[31:0];
    end else if (op == MD_DIV && b != 0) begin
      q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0];
    end else if (op == MD_DIVU && b != 0) begin
      lo_m = a / b; hi_m = a % b;
    end
  endtask
  task automatic check_hilo(input string n);
    e_valid = 1'b1; md_op = MD_MFHI;
    #1 chk({n, "_hi"}, result, hi_m);
    md_op = MD_MFLO;
    #1 chk({n, "_lo"}, result, lo_m);
    e_valid = 1'b0; md_op = MD_NONE;
  endtask
  task automatic wait_busy(input string n, input int exp);
    int c = 0;
    while (md_busy && c < 200) begin
      c++;
      tick();
    end
    chk({n, "_busy_cycles"}, c, exp);
  endtask
  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string n);
    e_valid = 1'b1; md_op = op; fwd_rs = a; fwd_rt = b;
    #1 chk({n, "_start"}, md_start, 1);
    tick();
    idle();
    model_md(op, a, b);
    wait_busy(n, is_mul(op) ? 5 : 10);
    check_hilo(n);
  endtask
  task automatic run_mt(input logic [3:0] op, input logic [31:0] v, input string n);
    e_valid = 1'b1; md_op = op; fwd_rs = v;
    #1 chk({n, "_nostart"}, md_start, 0);
    tick();
    idle();
    if (op == MD_MTHI) hi_m = v; else lo_m = v;
    check_hilo(n);
  endtask
  initial begin
    logic [3:0] ops[6];
    logic [3:0] op;
    logic [31:0] a, b, imm;
    logic bs;
    ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO};
    tbl[0]  = '{ALU_ADD,  0, 0, 32'd5,        32'd7,        32'd0,      32'd0,      32'd12,        "add"};
    tbl[1]  = '{ALU_SUB,  0, 0, 32'd3,        32'd5,        32'd0,      32'd0,      32'hFFFFFFFE,  "sub"};
    tbl[2]  = '{ALU_AND,  0, 0, 32'hF0F0,     32'hFF00,     32'd0,      32'd0,      32'hF000,      "and"};
    tbl[3]  = '{ALU_OR,   0, 0, 32'hF0F0,     32'hFF00,     32'd0,      32'd0,      32'hFFF0,      "or"};
    tbl[4]  = '{ALU_XOR,  0, 0, 32'hF0F0,     32'hFF00,     32'd0,      32'd0,      32'h0FF0,      "xor"};
    tbl[5]  = '{ALU_NOR,  0, 0, 32'd0,        32'd0,        32'd0,      32'd0,      32'hFFFFFFFF,  "nor"};
    tbl[6]  = '{ALU_SLT,  0, 0, 32'hFFFFFFFF, 32'd1,        32'd0,      32'd0,      32'd1,         "slt"};
    tbl[7]  = '{ALU_SLTU, 0, 0, 32'hFFFFFFFF, 32'd1,        32'd0,      32'd0,      32'd0,         "sltu"};
    tbl[8]  = '{ALU_LUI,  1, 0, 32'd0,        32'd0,        32'hABCD,   32'd0,      32'hABCD0000,  "lui"};
    tbl[9]  = '{ALU_ADD,  0, 1, 32'd1,        32'd2,        32'd0,      32'h3000,   32'h3008,      "link"};
    tbl[10] = '{ALU_ADD,  1, 0, 32'd16,       32'd99,       32'hFFFFFFFF, 32'd0,    32'd15,        "addi"};
    tbl[11] = '{4'd12,    0, 0, 32'd16,       32'd99,       32'd0,      32'd0,      32'd0,         "undef"};
    tbl[12] = '{ALU_ADD,  0, 0, 32'h7FFFFFFF, 32'd1,        32'd0,      32'd0,      32'h80000000,  "wrap"};
    tbl[13] = '{ALU_SUB,  0, 1, 32'd1,        32'd2,        32'd0,      32'hFFFFFFFC, 32'h4,       "link_wrap"};
    idle();
    pc = '0; fwd_rs = '0; fwd_rt = '0; ext_imm = '0;
    pc16 = '0; rs16 = '0; rt16 = '0; imm16 = '0; md_op16 = MD_NONE; link16 = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    chk("reset_busy", md_busy, 0);
    check_hilo("reset");
    e_valid = 1'b1; md_op = MD_MULT;
    #1 chk("start_comb", md_start, 1);
    e_valid = 1'b0;
    #1 chk("start_bubble", md_start, 0);
    idle();
    for (int i = 0; i < 14; i++) begin
      alu_op = tbl[i].op; b_sel = tbl[i].bsel; is_link = tbl[i].link;
      fwd_rs = tbl[i].rs; fwd_rt = tbl[i].rt; ext_imm = tbl[i].imm; pc = tbl[i].pc;
      #1 chk(tbl[i].name, result, tbl[i].exp);
      chk({tbl[i].name, "_rt_pass"}, rt_pass, tbl[i].rt);
    end
    idle();
    alu_op = ALU_SLT; rs16 = 16'hFFFF; rt16 = 16'd1;
    #1 chk("slt16", result16, 32'd1);
    alu_op = ALU_LUI; b_sel = 1'b1; imm16 = 16'h00AB;
    #1 chk("lui16", result16, 32'hAB00);
    idle();
    tick();
    run_md(MD_MULT, 32'hFFFFFFFD, 32'd7, "mult_neg");
    chk("mult_neg_hi_const", hi_m, 32'hFFFFFFFF);
    chk("mult_neg_lo_const", lo_m, 32'hFFFFFFEB);
    run_md(MD_DIV, 32'hFFFFFFF9, 32'd2, "div_neg");
    run_md(MD_DIVU, 32'h80000000, 32'd0, "divu_zero");
    run_md(MD_DIV, 32'h80000000, 32'hFFFFFFFF, "div_min");
    e_valid = 1'b1; md_op = MD_MULTU; fwd_rs = 32'd1000; fwd_rt = 32'd3;
    #1 tick();
    model_md(MD_MULTU, 32'd1000, 32'd3);
    fwd_rs = 32'hFFFFFFFF; fwd_rt = 32'h10;
    for (int i = 0; i < 200 && md_busy; i++) begin
      #1 chk("b2b_no_start", md_start, 0);
      tick();
    end
    md_op = MD_MFHI;
    #1 chk("b2b_first_hi", result, hi_m);
    md_op = MD_MFLO;
    #1 chk("b2b_first_lo", result, lo_m);
    md_op = MD_MULTU;
    #1 chk("b2b_reissue_start", md_start, 1);
    tick();
    idle();
    model_md(MD_MULTU, 32'hFFFFFFFF, 32'h10);
    wait_busy("b2b_second", 5);
    check_hilo("b2b_second");
    e_valid = 1'b1; md_op = MD_DIV; fwd_rs = 32'd100; fwd_rt = 32'd7;
    #1 tick();
    model_md(MD_DIV, 32'd100, 32'd7);
    e_valid = 1'b1; md_op = MD_MTHI; fwd_rs = 32'h1234;
    tick();
    idle();
    wait_busy("mthi_busy", 9);
    check_hilo("mthi_busy");
    run_mt(MD_MTLO, 32'h55, "mtlo_idle");
    fwd_rs = 32'h77; md_op = MD_MTLO; e_valid = 1'b0;
    tick();
    idle();
    check_hilo("mtlo_bubble");
    e_valid = 1'b1; md_op = MD_DIV; fwd_rs = 32'd1000; fwd_rt = 32'd9;
    #1 tick();
    idle();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hi_m = '0; lo_m = '0;
    chk("abort_busy", md_busy, 0);
    check_hilo("abort");
    repeat (15) tick();
    check_hilo("abort_late");
    run_mt(MD_MTHI, 32'hCAFE, "pre_rst");
    e_valid = 1'b1; md_op = MD_MTLO; fwd_rs = 32'h99; reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    hi_m = '0; lo_m = '0;
    check_hilo("mt_reset");
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 5)];
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 31);
      if (op == MD_MTHI || op == MD_MTLO) run_mt(op, a, "rnd_mt");
      else run_md(op, a, b, "rnd_md");
    end
    for (int i = 0; i < 100; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom; b = $urandom; imm = $urandom; bs = 1'($urandom_range(0, 1));
      alu_op = op; b_sel = bs; fwd_rs = a; fwd_rt = b; ext_imm = imm;
      e_valid = 1'($urandom_range(0, 1)); md_op = MD_NONE;
      #1 chk("rnd_alu", result, alu_ref(op, a, bs ? imm : b));
    end
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/e_stage_md.md
# e_stage_md

Parametrised execute stage for the five-stage MIPS pipeline, successor to the single-cycle-ALU execute stage. Adds a multi-cycle multiply/divide unit with architectural HI/LO registers, a start/busy handshake for the hazard unit, and configurable datapath width and MDU latencies. It sits between the D/E and E/M pipeline registers. The ALU path stays combinational; the MDU is the only sequential state.

## Interface
Parameters:
- WIDTH, 32, datapath width; must be even and ≥ 8
- MULT_CYCLES, 5, busy cycles for mult/multu; ≥ 1
- DIV_CYCLES, 10, busy cycles for div/divu; ≥ 1

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- e_valid  in  1  E holds a real instruction; 0 = bubble, nothing starts or writes
- alu_op  in  4  ALU function; encoding from the package
- b_sel  in  1  0 = fwd_rt, 1 = ext_imm as ALU B operand
- md_op  in  4  MDU function; encoding from the package
- is_link  in  1  jal/jalr; result = pc + 8
- pc  in  WIDTH  PC of the E instruction
- fwd_rs, fwd_rt  in  WIDTH  forwarded operands
- ext_imm  in  WIDTH  extended immediate
- result  out  WIDTH  to the E/M register: pc+8, HI/LO or ALU output
- rt_pass  out  WIDTH  fwd_rt passed through for stores
- md_start  out  1  combinational; an MDU operation is accepted this cycle
- md_busy  out  1  registered; MDU computing

## Operation
- ALU ops: ADD/SUB (wrap-around, no overflow trap), AND, OR, XOR, NOR, SLT (signed, result 0/1), SLTU, LUI (B << WIDTH/2). An undefined code yields 0.
- md_op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8. Codes 9–15 behave as NONE.
- md_start = e_valid & !md_busy & md_op ∈ {MULT..DIVU}.
- On start, latch the operands fwd_rs and fwd_rt and the op, load the counter with MULT_CYCLES or DIV_CYCLES, and set md_busy on the next edge.
- Busy: the counter decrements each cycle. On the edge where the counter goes 1→0:
  - md_busy clears.
  - HI/LO are written with the result computed from the latched operands.
- Arithmetic results:
  - MULT/MULTU: 2·WIDTH-bit product; HI = upper half, LO = lower half.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Signed MIN/−1: LO = MIN, HI = 0.
  - Divisor 0: HI and LO unchanged; busy still runs DIV_CYCLES.
- MTHI/MTLO: with e_valid and not busy, write fwd_rs at the edge. While busy the write is ignored, because the hazard unit stalls such instructions.
- MFHI/MFLO: result = HI/LO combinationally. Correctness while busy is the hazard unit's responsibility.
- A new MDU op presented while busy is not started. md_start stays 0 and D is held by the hazard unit.
- result priority: is_link → pc + 8 (width-truncated); else MFHI/MFLO → HI/LO; else ALU output.
- rt_pass = fwd_rt always.

## Timing
- Reset values: md_busy = 0, counter = 0, HI = 0, LO = 0, latched operands = 0. md_start and result follow their inputs combinationally.
- Reset asserted mid-operation aborts the operation: HI/LO return to 0 and the result is never written.
- ALU, link and MF paths have zero latency (same cycle).
- Multiply: start in cycle t, md_busy = 1 for cycles t+1 … t+MULT_CYCLES, HI/LO new from cycle t+MULT_CYCLES+1. Divide timing is the same with DIV_CYCLES.
- The hazard unit stalls any MD-class instruction in D while (md_start | md_busy).
- Back-to-back ops: a new start is accepted in the first cycle with md_busy = 0.
- MTHI/MTLO in the same cycle as reset: reset wins.

## Structure
- Package e_stage_pkg holds the alu_op and md_op localparam encodings, an is_md_start(op) function, and the default latencies.
- Sub-module md_unit contains the counter, busy flag, operand latches and HI/LO, parametrised on WIDTH, MULT_CYCLES and DIV_CYCLES. The top level holds the ALU, the B-mux and the result mux.
- Division uses the behavioural / and % operators on the latched operands. Cycle count is modelled by the counter, not by an iterative divider.

## Test plan
- MULT, rs = −3 (0xFFFFFFFD), rt = 7, WIDTH = 32 → md_start = 1 in the issue cycle, md_busy = 1 for exactly 5 cycles, then HI = 0xFFFFFFFF and LO = 0xFFFFFFEB; MFLO returns 0xFFFFFFEB.
- DIV −7 / 2 → after 10 busy cycles LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1). DIVU 0x80000000 / 0 → HI/LO unchanged.
- Second MULTU issued while busy → md_start = 0, HI/LO from the first op only. Reissued in the first non-busy cycle → accepted.
- MTHI 0x1234 while busy → ignored. MTLO 0x55 while idle → LO = 0x55 next cycle. e_valid = 0 with MTLO → no write.
- Reset pulse at busy cycle 3 of DIV → md_busy = 0 and HI = LO = 0 the next cycle, with no late write.
- Link: is_link = 1, pc = 0x3000 → result = 0x3008. ALU: SLT −1 vs 1 → 1, SLTU → 0, LUI ext_imm = 0xABCD → 0xABCD0000. Repeat SLT and LUI with WIDTH = 16: LUI 0x00AB → 0xAB00.
